// File: rtl/mru_pkg.sv
// Shared types and helpers for the MRU stack tracker.
package mru_pkg;

    typedef enum logic [1:0] {S_IDLE, S_PUSH, S_WAIT} state_t;

    localparam int unsigned MAX_CH = 16;

    // A slot is {valid, idx}; valid sits in the top bit.
    function automatic int unsigned slot_width(input int unsigned idx_w);
        return idx_w + 1;
    endfunction

    function automatic logic [3:0] first_set(input logic [MAX_CH-1:0] vec);
        logic [3:0] idx;
        idx = '0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/mru_edge_det.sv
// Tick-qualified rising-edge detector for the button levels.
module mru_edge_det #(
    parameter int unsigned N_CH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick,
    input  logic [N_CH-1:0] btn,
    output logic [N_CH-1:0] press
);

    logic [N_CH-1:0] btn_prev;

    always_ff @(posedge clk) begin
        if (!rst) begin
            btn_prev <= '0;
        end else if (tick) begin
            btn_prev <= btn;
        end
    end

    assign press = tick ? (btn & ~btn_prev) : '0;

endmodule

// File: rtl/mru_stack.sv
// Most-recently-used button tracker with LED residency, eviction report and tick gating.
// MRU_DEDUP_EN selects move-to-front de-duplication; undefined gives legacy always-miss pushes.
module mru_stack
    import mru_pkg::*;
#(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned DEPTH = 3,
    parameter int unsigned IDX_W = $clog2(N_CH),
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [N_CH-1:0]  btn,
    output logic [N_CH-1:0]  led,
    output logic             top_valid,
    output logic [IDX_W-1:0] top_idx,
    output logic [CNT_W-1:0] count,
    output logic             evict_valid,
    output logic [IDX_W-1:0] evict_idx
);

    localparam int unsigned SLOT_W = slot_width(IDX_W);

    state_t              state_q;
    logic [IDX_W-1:0]    sel_q;
    logic [SLOT_W-1:0]   slot_q   [DEPTH];
    logic [SLOT_W-1:0]   slot_nxt [DEPTH];
    logic [N_CH-1:0]     press;
    logic [MAX_CH-1:0]   press_wide;
    logic [IDX_W-1:0]    first_idx;
    logic                hit;
    logic                full;
    int unsigned         hit_pos;
    int unsigned         shift_lim;
    logic [N_CH-1:0]     led_nxt;
    logic [CNT_W-1:0]    count_nxt;
    logic                evict_nxt;

    mru_edge_det #(
        .N_CH (N_CH)
    ) u_edge_det (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .btn   (btn),
        .press (press)
    );

    always_comb begin
        press_wide             = '0;
        press_wide[N_CH-1:0]   = press;
        first_idx              = IDX_W'(first_set(press_wide));
        hit                    = 1'b0;
        hit_pos                = 0;
`ifdef MRU_DEDUP_EN
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!hit && slot_q[i][SLOT_W-1] && (slot_q[i][IDX_W-1:0] == sel_q)) begin
                hit     = 1'b1;
                hit_pos = i;
            end
        end
`endif
        full      = (count == CNT_W'(DEPTH));
        // A hit only shifts the slots above it; a miss shifts the whole stack.
        shift_lim = hit ? hit_pos : DEPTH - 1;
        slot_nxt  = slot_q;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            if (i <= shift_lim) begin
                slot_nxt[i] = slot_q[i-1];
            end
        end
        slot_nxt[0] = {1'b1, sel_q};
        evict_nxt   = !hit && full;
        count_nxt   = (hit || full) ? count : count + 1'b1;
        led_nxt     = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (slot_nxt[i][SLOT_W-1]) begin
                led_nxt[slot_nxt[i][IDX_W-1:0]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
            led         <= '0;
            top_valid   <= 1'b0;
            top_idx     <= '0;
            count       <= '0;
            evict_valid <= 1'b0;
            evict_idx   <= '0;
        end else begin
            evict_valid <= 1'b0;
            if (tick) begin
                unique case (state_q)
                    S_IDLE: begin
                        if (|press) begin
                            sel_q   <= first_idx;
                            state_q <= S_PUSH;
                        end
                    end
                    S_PUSH: begin
                        slot_q    <= slot_nxt;
                        led       <= led_nxt;
                        top_valid <= 1'b1;
                        top_idx   <= sel_q;
                        count     <= count_nxt;
                        if (evict_nxt) begin
                            evict_valid <= 1'b1;
                            evict_idx   <= slot_q[DEPTH-1][IDX_W-1:0];
                        end
                        state_q <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (btn == '0) begin
                            state_q <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/mru_stack.md
Name: mru_stack

Overview:
- Parametrised most-recently-used tracker. It records which of N_CH push-button channels were pressed most recently, keeping up to DEPTH entries ordered newest to oldest.
- Drives one LED per channel, lit while that channel is resident in the stack. Also reports the newest entry, the occupancy and evictions.
- Sits behind the board timer: all state advances only on cycles where the single-cycle `tick` strobe is high.
- Successor to the fixed 4-channel / 3-deep tracker. Adds parametrisation, press-edge detection, move-to-front de-duplication and an eviction report.

Parameters:
- N_CH, 4, number of button/LED channels (2..16).
- DEPTH, 3, stack entries (1..N_CH).
- IDX_W, $clog2(N_CH), channel index width (derived; not overridden).
- CNT_W, $clog2(DEPTH+1), occupancy width (derived).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- tick  in  1  sample strobe from timer, one clk wide.
- btn  in  N_CH  button levels, already synchronised, active-high.
- led  out  N_CH  led[c]=1 iff channel c is resident in the stack.
- top_valid  out  1  stack non-empty.
- top_idx  out  IDX_W  channel at stack position 0 (newest); 0 when empty.
- count  out  CNT_W  number of valid entries.
- evict_valid  out  1  one-clk pulse when an entry falls off the bottom.
- evict_idx  out  IDX_W  evicted channel; valid only with evict_valid.

Behaviour:
- **Clock and reset.** Single clk domain. Reset is synchronous active-low: on a clk edge with rst=0, all stack entries become invalid, count=0, led=0, top_valid=0, top_idx=0, evict_valid=0, evict_idx=0, btn history=0, FSM=S_IDLE. Reset wins over tick.
- **Storage.** Stack is DEPTH slots, each holding {valid, idx}. Slot 0 is the newest. Valid slots are always contiguous from slot 0.
- **FSM** (advances only when tick=1; holds otherwise):
  - S_IDLE: compute new presses as press = btn & ~btn_prev, where btn_prev is captured on each tick. If press≠0, latch sel = lowest set index of press and go to S_PUSH.
  - S_PUSH: perform the update (below), then go to S_WAIT.
  - S_WAIT: stay until btn==0 on a tick, then go to S_IDLE. Holding a button or rolling to a second button produces no further push until all buttons are released.
- **Update, hit** (sel already resident at slot k): slots 0..k-1 shift down by one, slot 0 = sel. count is unchanged; no eviction. If k=0, the stack is unchanged.
- **Update, miss, not full:** all slots shift down by one, slot 0 = sel, count+1.
- **Update, miss, full** (count==DEPTH): slot DEPTH-1 is dropped. evict_valid=1 and evict_idx=old slot DEPTH-1 for exactly one clk. count stays DEPTH.
- **Simultaneous presses:** lowest index wins. The other channels are ignored for that press.
- **Outputs:**
  - led, top_valid, top_idx and count are registered and reflect the stack after the update, on the clk following the S_PUSH tick.
  - Latency from a press edge sampled on tick n to updated outputs is tick n+1 plus one clk.
- **tick stuck high:** the block behaves as fully clk-rate.

Optional Feature:
- Macro: MRU_DEDUP_EN.
- Defined: hit/miss behaviour exactly as above (move-to-front, no duplicate slots).
- Undefined: legacy mode. Every push is treated as a miss, so duplicates may occupy several slots and led is the OR over all valid slots. Eviction still reports the dropped slot, even if that channel remains resident elsewhere.

Decomposition:
- Shared package mru_pkg holds:
  - state typedef enum logic [1:0] {S_IDLE, S_PUSH, S_WAIT};
  - slot struct typedef {logic valid; logic [IDX_W-1:0] idx} as a parameterised-width helper, or a function returning the slot width;
  - function first_set(vec) returning the lowest set index.
- One sub-module: mru_edge_det, the tick-qualified rising-edge detector producing press[N_CH-1:0]. The stack/FSM stays in mru_stack.

Test Plan:
- Reset/idle: rst=0 for 2 clk with btn=4'b1111 and tick=1 → led=0, count=0, top_valid=0, no evict_valid; after release, the FSM is in S_IDLE.
- Fill and evict (N_CH=4, DEPTH=3): press ch0, ch1, ch2, ch3 separately, releasing between each → after ch3, stack=[3,2,1], led=4'b1110, count=3, a single evict_valid pulse with evict_idx=0.
- Move-to-front (MRU_DEDUP_EN): from stack [3,2,1], press ch1 → stack [1,3,2], count=3, no evict, led unchanged at 4'b1110, top_idx=1.
- Legacy (MRU_DEDUP_EN undefined): from [3,2,1], press ch3 → [3,3,2], evict_idx=1, led=4'b1100.
- Priority and hold: btn=4'b0110 on one tick, then held for 5 ticks → exactly one push with top_idx=1; no push until btn==0 is sampled.
- Tick gating and mid-operation reset: toggle btn between ticks only (tick low) → no change. Assert rst=0 on the clk after entering S_PUSH → all outputs zero next clk, with no partial update.
